// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo motion sequencer.
package servo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  localparam int DEF_FRAME_CYCLES = 1_000_000;
  localparam int DEF_MAX_POS      = 85;
  localparam int DEF_HOME_POS     = 8;
  localparam int DEF_STEP         = 1;

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter with a registered one-cycle frame_tick,
// high while the counter holds FRAME_CYCLES-1.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(FRAME_CYCLES - 2);

  logic [CW-1:0] cnt;

  // Count 0..FRAME_CYCLES-1; raise the tick one cycle early so it is
  // registered yet coincides with the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == LAST_CNT) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
      frame_tick <= (cnt == PRE_CNT);
    end
  end

endmodule

// File: rtl/servo_seq_ctrl.sv
// Multi-joint servo sequencer: accepts per-joint targets over valid/ready and
// moves each joint toward its target once per frame through one shared,
// time-multiplexed step slot. Define SERVO_SEQ_SLEW_EN for rate-limited
// motion (STEP per frame); otherwise each joint jumps to its target.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_JOINTS   = 4,
  parameter int DATA_W       = 16,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int STEP         = DEF_STEP,
  parameter int MAX_POS      = DEF_MAX_POS,
  parameter int HOME_POS     = DEF_HOME_POS,
  localparam int JW          = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [JW-1:0]                cmd_joint,
  input  logic [DATA_W-1:0]            cmd_pos,
  input  logic                         cmd_en,
  output logic                         cmd_err,
  output logic [NUM_JOINTS*DATA_W-1:0] pos_out,
  output logic [NUM_JOINTS-1:0]        en_out,
  output logic [NUM_JOINTS-1:0]        moving,
  output logic                         all_settled,
  output logic                         frame_tick
);

  state_t              state, state_nx;
  logic [JW-1:0]       idx, idx_nx;
  logic                upd_en;
  logic [DATA_W-1:0]   pos    [NUM_JOINTS];
  logic [DATA_W-1:0]   target [NUM_JOINTS];
  logic [NUM_JOINTS-1:0] en;
  logic                accept;
  logic [31:0]         joint_ext;
  logic                joint_ok;
  logic                idx_last;

  function automatic logic [DATA_W-1:0] clamp_pos(input logic [DATA_W-1:0] p);
    return (p > DATA_W'(MAX_POS)) ? DATA_W'(MAX_POS) : p;
  endfunction

  // Move cur toward goal by at most the step limit, landing exactly on goal.
  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] goal);
    logic [DATA_W-1:0] stp;
`ifdef SERVO_SEQ_SLEW_EN
    stp = DATA_W'(STEP);
`else
    // STEP has no effect: an all-ones limit turns every move into a jump.
    stp = DATA_W'(STEP) | {DATA_W{1'b1}};
`endif
    if (goal >= cur) return ((goal - cur) <= stp) ? goal : cur + stp;
    else             return ((cur - goal) <= stp) ? goal : cur - stp;
  endfunction

  servo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign accept    = cmd_valid && cmd_ready;
  assign joint_ext = 32'(cmd_joint);
  assign joint_ok  = joint_ext < 32'(NUM_JOINTS);
  assign idx_last  = 32'(idx) == 32'(NUM_JOINTS - 1);

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Scheduler next state: a tick starts one update slot per joint.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cmd_ready = 1'b0;
    upd_en    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (frame_tick) begin
          state_nx = UPDATE;
          idx_nx   = '0;
        end
      end
      UPDATE: begin
        upd_en = 1'b1;
        if (idx_last) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-joint targets, enables and positions; commands only land in IDLE
  // and position steps only in UPDATE, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err <= 1'b0;
      en      <= '0;
      for (int j = 0; j < NUM_JOINTS; j++) begin
        pos[j]    <= DATA_W'(HOME_POS);
        target[j] <= DATA_W'(HOME_POS);
      end
    end else begin
      cmd_err <= accept && !joint_ok;
      for (int j = 0; j < NUM_JOINTS; j++) begin
        if (accept && joint_ok && (joint_ext == 32'(j))) begin
          if (cmd_en) begin
            target[j] <= clamp_pos(cmd_pos);
            en[j]     <= 1'b1;
          end else begin
            target[j] <= pos[j];
            en[j]     <= 1'b0;
          end
        end
        if (upd_en && (32'(idx) == 32'(j))) begin
          pos[j] <= step_toward(pos[j], target[j]);
        end
      end
    end
  end

  // Flatten positions and derive motion flags straight from the registers.
  always_comb begin
    pos_out = '0;
    moving  = '0;
    for (int j = 0; j < NUM_JOINTS; j++) begin
      pos_out[j*DATA_W +: DATA_W] = pos[j];
      moving[j]                   = pos[j] != target[j];
    end
  end

  assign en_out      = en;
  assign all_settled = ~|moving;

endmodule
